// File: rtl/sm4_iter_core_if.sv
// Handshake bundle for sm4_iter_core: key load, block in, result out.
// The iv_load/iv chain-seed signals exist only when SM4_CBC_EN is defined.
interface sm4_iter_core_if;
   logic         key_valid;
   logic         key_ready;
   logic [127:0] key;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic         in_decrypt;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic         key_loaded;
`ifdef SM4_CBC_EN
   logic         iv_load;
   logic [127:0] iv;

   modport master (
      output key_valid, key, in_valid, in_data, in_decrypt, out_ready, iv_load, iv,
      input  key_ready, in_ready, out_valid, out_data, key_loaded
   );

   modport slave (
      input  key_valid, key, in_valid, in_data, in_decrypt, out_ready, iv_load, iv,
      output key_ready, in_ready, out_valid, out_data, key_loaded
   );
`else
   modport master (
      output key_valid, key, in_valid, in_data, in_decrypt, out_ready,
      input  key_ready, in_ready, out_valid, out_data, key_loaded
   );

   modport slave (
      input  key_valid, key, in_valid, in_data, in_decrypt, out_ready,
      output key_ready, in_ready, out_valid, out_data, key_loaded
   );
`endif
endinterface

// File: rtl/sm4_iter_core.sv
// Iterative SM4 engine: one shared round datapath runs both key expansion and en/decryption.
// Defining SM4_CBC_EN adds a CBC chain register seeded through iv_load/iv.
module sm4_iter_core #(
   parameter int ROUNDS_PER_CYCLE = 1
) (
   input logic            clk,
   input logic            rst,
   sm4_iter_core_if.slave bus
);

   if (!(ROUNDS_PER_CYCLE == 1  || ROUNDS_PER_CYCLE == 2  || ROUNDS_PER_CYCLE == 4 ||
         ROUNDS_PER_CYCLE == 8  || ROUNDS_PER_CYCLE == 16 || ROUNDS_PER_CYCLE == 32)) begin : g_bad_param
      $error("sm4_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8, 16 or 32");
   end

   localparam logic [4:0] STEP = 5'(ROUNDS_PER_CYCLE);
   localparam logic [4:0] LAST = 5'(32 - ROUNDS_PER_CYCLE);

   localparam logic [127:0] FK = 128'ha3b1bac656aa3350677d9197b27022dc;

   localparam logic [0:255][7:0] SBOX = {
      128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
      128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
      128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
      128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
      128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
      128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
      128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
      128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
   };

   typedef enum logic [2:0] {NOKEY, KEYEXP, IDLE, CRYPT, HOLD} state_t;

   function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
      return (v << n) | (v >> (32 - n));
   endfunction

   function automatic logic [31:0] tau(input logic [31:0] w);
      return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
   endfunction

   function automatic logic [31:0] lData(input logic [31:0] b);
      return b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
   endfunction

   function automatic logic [31:0] lKey(input logic [31:0] b);
      return b ^ rotl(b, 13) ^ rotl(b, 23);
   endfunction

   // CK[i] byte j is (4i+j)*7 mod 256, so the constant is generated instead of stored.
   function automatic logic [31:0] ckWord(input logic [4:0] i);
      logic [31:0] w;
      w = '0;
      for (int j = 0; j < 4; j++) begin
         w[31 - 8*j -: 8] = 8'((32'(i) * 4 + j) * 7);
      end
      return w;
   endfunction

   state_t        state_q;
   logic [4:0]    ctr_q;
   logic [127:0]  win_q;
   logic [31:0]   rk_q [32];
   logic [127:0]  out_data_q;
   logic          out_valid_q;
   logic          key_ready_q;
   logic          in_ready_q;
   logic          key_loaded_q;
   logic          dec_q;

   logic          isKeyExp;
   logic          keyFire;
   logic          blockFire;
   logic          lastStep;
   logic [127:0]  win_d;
   logic [4:0]    roundIdx;
   logic [31:0]   roundMix;
   logic [31:0]   roundSub;
   logic [31:0]   roundNew;
   logic [31:0]   rkNew [ROUNDS_PER_CYCLE];
   logic [127:0]  result;
   logic [127:0]  blockIn;

   assign isKeyExp  = (state_q == KEYEXP);
   assign keyFire   = bus.key_valid & key_ready_q;
   assign blockFire = bus.in_valid & in_ready_q & ~bus.key_valid;
   assign lastStep  = (ctr_q == LAST);

   // Window holds four consecutive words (K or X); each round shifts one new word in.
   always_comb begin
      win_d    = win_q;
      roundIdx = '0;
      roundMix = '0;
      roundSub = '0;
      roundNew = '0;
      rkNew    = '{default: '0};
      for (int r = 0; r < ROUNDS_PER_CYCLE; r++) begin
         roundIdx = ctr_q + 5'(r);
         roundMix = isKeyExp ? ckWord(roundIdx) : (dec_q ? rk_q[~roundIdx] : rk_q[roundIdx]);
         roundSub = tau(win_d[95:64] ^ win_d[63:32] ^ win_d[31:0] ^ roundMix);
         roundNew = win_d[127:96] ^ (isKeyExp ? lKey(roundSub) : lData(roundSub));
         win_d    = {win_d[95:0], roundNew};
         rkNew[r] = roundNew;
      end
   end

   assign result = {win_d[31:0], win_d[63:32], win_d[95:64], win_d[127:96]};

`ifdef SM4_CBC_EN
   logic [127:0] c_q;
   logic [127:0] mask_q;
   logic [127:0] chainEff;

   assign chainEff = bus.iv_load ? bus.iv : c_q;
   assign blockIn  = bus.in_decrypt ? bus.in_data : (bus.in_data ^ chainEff);
`else
   assign blockIn  = bus.in_data;
`endif

   // Round-key store is plain storage; key_loaded guards against using a stale schedule.
   always_ff @(posedge clk) begin
      if (isKeyExp) begin
         for (int r = 0; r < ROUNDS_PER_CYCLE; r++) begin
            rk_q[ctr_q + 5'(r)] <= rkNew[r];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= NOKEY;
         ctr_q        <= '0;
         win_q        <= '0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         key_ready_q  <= 1'b1;
         in_ready_q   <= 1'b0;
         key_loaded_q <= 1'b0;
         dec_q        <= 1'b0;
`ifdef SM4_CBC_EN
         c_q          <= '0;
         mask_q       <= '0;
`endif
      end else begin
`ifdef SM4_CBC_EN
         if (bus.iv_load && (state_q == NOKEY || state_q == IDLE)) begin
            c_q <= bus.iv;
         end
`endif
         unique case (state_q)
            NOKEY: begin
               if (keyFire) begin
                  state_q     <= KEYEXP;
                  win_q       <= bus.key ^ FK;
                  ctr_q       <= '0;
                  key_ready_q <= 1'b0;
               end
            end
            KEYEXP: begin
               win_q <= win_d;
               ctr_q <= ctr_q + STEP;
               if (lastStep) begin
                  state_q      <= IDLE;
                  key_loaded_q <= 1'b1;
                  key_ready_q  <= 1'b1;
                  in_ready_q   <= 1'b1;
               end
            end
            IDLE: begin
               if (keyFire) begin
                  state_q      <= KEYEXP;
                  win_q        <= bus.key ^ FK;
                  ctr_q        <= '0;
                  key_loaded_q <= 1'b0;
                  key_ready_q  <= 1'b0;
                  in_ready_q   <= 1'b0;
               end else if (blockFire) begin
                  state_q     <= CRYPT;
                  win_q       <= blockIn;
                  ctr_q       <= '0;
                  dec_q       <= bus.in_decrypt;
                  key_ready_q <= 1'b0;
                  in_ready_q  <= 1'b0;
`ifdef SM4_CBC_EN
                  mask_q <= bus.in_decrypt ? chainEff : '0;
                  if (bus.in_decrypt) begin
                     c_q <= bus.in_data;
                  end
`endif
               end
            end
            CRYPT: begin
               win_q <= win_d;
               ctr_q <= ctr_q + STEP;
               if (lastStep) begin
                  state_q     <= HOLD;
                  out_valid_q <= 1'b1;
`ifdef SM4_CBC_EN
                  out_data_q  <= result ^ mask_q;
                  if (!dec_q) begin
                     c_q <= result;
                  end
`else
                  out_data_q  <= result;
`endif
               end
            end
            HOLD: begin
               if (bus.out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  key_ready_q <= 1'b1;
                  in_ready_q  <= 1'b1;
               end
            end
            default: state_q <= NOKEY;
         endcase
      end
   end

   // A simultaneous key request masks in_ready so the block waits for the new schedule.
   assign bus.key_ready  = key_ready_q;
   assign bus.in_ready   = in_ready_q & ~bus.key_valid;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_data   = out_data_q;
   assign bus.key_loaded = key_loaded_q;

endmodule
